// File: rtl/ff_pipe.sv
// ff_pipe: elastic pipeline register of DEPTH stages, WIDTH bits each.
// Each stage carries its own valid bit. Stages move under a combinational
// ready chain, so empty stages (bubbles) collapse even while the output is
// stalled. A registered occupancy count and a synchronous flush are included.
//
// Optional feature macro: FF_PIPE_DATA_RESET_EN
//   defined   -> data registers are reset by res_n and cleared by flush.
//   undefined -> only the valid bits are reset and flushed. The data
//                registers carry no reset.
module ff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       res_n,
  input  logic [WIDTH-1:0]           D,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           Q,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_q   [DEPTH];
  logic [WIDTH-1:0] data_d   [DEPTH];
  logic [WIDTH-1:0] up_data  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] up_valid;
  logic [DEPTH:0]   rdy;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             accept;
  logic             emit;

  // Upstream source of each stage: the pipe input for stage 0, the previous stage otherwise.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_up
    if (gi == 0) begin : g_first
      assign up_data[gi]  = D;
      assign up_valid[gi] = in_valid;
    end else begin : g_rest
      assign up_data[gi]  = data_q[gi-1];
      assign up_valid[gi] = valid_q[gi-1];
    end
  end

  // Ready chain, evaluated from the output side back to the input side.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = ~valid_q[i] | rdy[i+1];
    end
  end

  // Hold in_ready low while reset is asserted. Flush also blocks new input.
  assign in_ready = rdy[0] & ~flush & res_n;
  assign accept   = in_valid & in_ready;
  assign emit     = valid_q[DEPTH-1] & out_ready;

  // Next valid bits: a stage loads when ready, and flush clears everything.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i]) valid_d[i] = up_valid[i];
    end
    if (flush) valid_d = '0;
  end

  // Next data words: a stage loads when ready, otherwise it holds.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
      if (rdy[i]) data_d[i] = up_data[i];
`ifdef FF_PIPE_DATA_RESET_EN
      if (flush) data_d[i] = '0;
`endif
    end
  end

  // Occupancy bookkeeping. It cannot wrap, because accept is impossible when full without emit.
  always_comb begin
    count_d = count_q + CW'(accept) - CW'(emit);
    if (flush) count_d = '0;
  end

  // Valid bits and count, asynchronously cleared.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

`ifdef FF_PIPE_DATA_RESET_EN
  // Data registers with reset, so that Q reads 0 after reset.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
    end
  end
`else
  // Data registers without reset. Their contents only matter when the matching valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
  end
`endif

  assign Q         = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_ff_pipe.sv
// Directed bench for ff_pipe. It uses a DEPTH=2 instance and a DEPTH=3 instance.
// Both instances share their inputs.
module tb_ff_pipe;

  logic       clk = 1'b0;
  logic       res_n;
  logic [7:0] D;
  logic       in_valid;
  logic       out_ready;
  logic       flush;

  logic       in_ready2, out_valid2, in_ready3, out_valid3;
  logic [7:0] Q2, Q3;
  logic [1:0] count2, count3;

  int n_vec = 0;
  int n_err = 0;

  ff_pipe #(.WIDTH(8), .DEPTH(2)) u_dut2 (
    .clk(clk), .res_n(res_n), .D(D), .in_valid(in_valid), .in_ready(in_ready2),
    .Q(Q2), .out_valid(out_valid2), .out_ready(out_ready), .flush(flush), .count(count2)
  );

  ff_pipe #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .res_n(res_n), .D(D), .in_valid(in_valid), .in_ready(in_ready3),
    .Q(Q3), .out_valid(out_valid3), .out_ready(out_ready), .flush(flush), .count(count3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one rising edge, then settle past it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] val);
    D = val;
    in_valid = 1'b1;
    tick();
  endtask

  initial begin
    res_n = 1'b0; D = 8'h33; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;

    // 1: reset with in_valid high.
    tick(); tick();
    chk("rst out_valid", out_valid2, 0);
    chk("rst count", count2, 0);
    chk("rst in_ready", in_ready2, 0);
    chk("rst in_ready3", in_ready3, 0);
    @(negedge clk);
    res_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rel in_ready", in_ready2, 1);
    chk("rel out_valid", out_valid2, 0);
`ifdef FF_PIPE_DATA_RESET_EN
    chk("rel Q zero", Q2, 0);
`endif

    // 2: streaming 1..5 through DEPTH=2 with out_ready high.
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      push(8'(k));
      chk($sformatf("strm count%0d", k), count2, (k == 1) ? 1 : 2);
      if (k == 1) chk("strm lat1 out_valid", out_valid2, 0);
      else begin
        chk($sformatf("strm Q%0d", k), Q2, k - 1);
        chk($sformatf("strm ov%0d", k), out_valid2, 1);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("strm tail Q", Q2, 8'h05);
    chk("strm tail ov", out_valid2, 1);
    chk("strm tail count", count2, 1);
    tick();
    chk("strm empty ov", out_valid2, 0);
    chk("strm empty count", count2, 0);

    // 3: back-pressure on DEPTH=2.
    out_ready = 1'b0;
    push(8'hA5);
    push(8'h5A);
    chk("bp count", count2, 2);
    chk("bp Q", Q2, 8'hA5);
    chk("bp ov", out_valid2, 1);
    D = 8'hFF; in_valid = 1'b1; #1;
    chk("bp in_ready full", in_ready2, 0);
    tick();
    chk("bp count held", count2, 2);
    chk("bp Q held", Q2, 8'hA5);
    in_valid = 1'b0; out_ready = 1'b1; #1;
    chk("bp Q before drain", Q2, 8'hA5);
    tick();
    chk("bp drain Q", Q2, 8'h5A);
    chk("bp drain count", count2, 1);
    tick();
    chk("bp drained ov", out_valid2, 0);
    chk("bp drained count", count2, 0);

    // Clear both pipes before the DEPTH=3 test.
    flush = 1'b1; tick(); flush = 1'b0;
    chk("pre flush count3", count3, 0);

    // 4: bubble collapse on DEPTH=3.
    out_ready = 1'b0;
    push(8'h11);
    in_valid = 1'b0; tick();
    D = 8'h22; in_valid = 1'b1; #1;
    chk("bub in_ready3 pre", in_ready3, 1);
    tick();
    chk("bub count3", count3, 2);
    chk("bub in_ready3", in_ready3, 1);
    chk("bub Q3", Q3, 8'h11);
    chk("bub ov3", out_valid3, 1);
    push(8'h33);
    chk("bub full count3", count3, 3);
    chk("bub full in_ready3", in_ready3, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bub drain Q3 a", Q3, 8'h22);
    chk("bub drain cnt a", count3, 2);
    tick();
    chk("bub drain Q3 b", Q3, 8'h33);
    chk("bub drain cnt b", count3, 1);
    tick();
    chk("bub drain ov3", out_valid3, 0);
    chk("bub drain cnt c", count3, 0);

    // 5: flush a full DEPTH=2 pipe while offering 0x77.
    out_ready = 1'b0;
    push(8'h61);
    push(8'h62);
    chk("fl full count", count2, 2);
    flush = 1'b1; D = 8'h77; in_valid = 1'b1; #1;
    chk("fl in_ready", in_ready2, 0);
    chk("fl ov during", out_valid2, 1);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl count", count2, 0);
    chk("fl ov", out_valid2, 0);
`ifdef FF_PIPE_DATA_RESET_EN
    chk("fl Q zero", Q2, 0);
`endif
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("fl no 0x77 ov%0d", k), out_valid2, 0);
    end

    // 6: async reset between edges mid-stream.
    push(8'h41);
    push(8'h42);
    chk("ar pre count", count2, 2);
    chk("ar pre ov", out_valid2, 1);
    #2;
    res_n = 1'b0;
    #1;
    chk("ar ov immediate", out_valid2, 0);
    chk("ar count immediate", count2, 0);
    chk("ar in_ready", in_ready2, 0);
    @(negedge clk);
    res_n = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("ar residual ov%0d", k), out_valid2, 0);
      chk($sformatf("ar residual cnt%0d", k), count2, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
